// File: rtl/regfile_param.sv
// regfile_param: 2R1W register file with clear sweep, optional zero reg; REGFILE_BYPASS_EN forwards same-cycle writes to reads
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic              o_busy,
  output logic              o_wr_drop
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata1_q, rdata2_q, rdata1_d, rdata2_d;
  logic              busy_q, wr_drop_q, wr_ok;
  assign wr_ok = (state_q == RUN) && i_we && !(ZERO_REG && i_waddr == '0);
`ifdef REGFILE_BYPASS_EN
  assign rdata1_d = (state_q == CLEAR || (ZERO_REG && i_raddr1 == '0)) ? '0 :
                    (wr_ok && i_waddr == i_raddr1) ? i_wdata : mem_q[i_raddr1];
  assign rdata2_d = (state_q == CLEAR || (ZERO_REG && i_raddr2 == '0)) ? '0 :
                    (wr_ok && i_waddr == i_raddr2) ? i_wdata : mem_q[i_raddr2];
`else
  assign rdata1_d = (state_q == CLEAR || (ZERO_REG && i_raddr1 == '0)) ? '0 : mem_q[i_raddr1];
  assign rdata2_d = (state_q == CLEAR || (ZERO_REG && i_raddr2 == '0)) ? '0 : mem_q[i_raddr2];
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      wr_drop_q <= 1'b0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
    end else begin
      wr_drop_q <= i_we && state_q == CLEAR;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      if (state_q == CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_q <= RUN;
          busy_q  <= 1'b0;
        end
      end else if (i_clr) begin
        state_q   <= CLEAR;
        clr_cnt_q <= '0;
        busy_q    <= 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state_q == CLEAR) mem_q[clr_cnt_q] <= '0;
      else if (wr_ok) mem_q[i_waddr] <= i_wdata;
    end
  end
  assign o_rdata1  = rdata1_q;
  assign o_rdata2  = rdata2_q;
  assign o_busy    = busy_q;
  assign o_wr_drop = wr_drop_q;
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed checks of regfile_param with ZERO_REG=1 and a ZERO_REG=0 twin
module tb_regfile_param;
  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, we = 1'b0;
  logic [4:0]  raddr1 = '0, raddr2 = '0, waddr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata1, rdata2, z_rdata1, z_rdata2;
  logic        busy, wr_drop, z_busy, z_wr_drop;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_raddr1(raddr1), .i_raddr2(raddr2),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .o_rdata1(rdata1), .o_rdata2(rdata2),
    .o_busy(busy), .o_wr_drop(wr_drop));

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) dut_nz (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_raddr1(raddr1), .i_raddr2(raddr2),
    .i_we(we), .i_waddr(waddr), .i_wdata(wdata), .o_rdata1(z_rdata1), .o_rdata2(z_rdata2),
    .o_busy(z_busy), .o_wr_drop(z_wr_drop));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 100);
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b1 || rdata1 !== 32'h0 || rdata2 !== 32'h0 || wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rd1=%h rd2=%h drop=%b, need 1/0/0/0", busy, rdata1, rdata2, wr_drop);
    end
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL reset_busy_len: busy fell after %0d cycles, need 32", n);
    end
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      step();
      checks++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || z_rdata1 !== 32'h0) begin
        errors++;
        $display("FAIL swept_zero r%0d: rd1=%h rd2=%h nz_rd1=%h, need 0", i, rdata1, rdata2, z_rdata1);
      end
    end
  endtask

  task automatic test_write_read;
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    step();
    checks++;
    if (rdata1 !== 32'hDEADBEEF || rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_read_r5: rd1=%h rd2=%h, need deadbeef", rdata1, rdata2);
    end
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE0009;
    step();
    waddr = 5'd10; wdata = 32'h0000A00A; raddr1 = 5'd9; raddr2 = 5'd5;
    step();
    we = 1'b0; raddr1 = 5'd10; raddr2 = 5'd9;
    step();
    checks++;
    if (rdata1 !== 32'h0000A00A || rdata2 !== 32'hCAFE0009) begin
      errors++;
      $display("FAIL back_to_back: rd1=%h rd2=%h, need 0000a00a/cafe0009", rdata1, rdata2);
    end
  endtask

  task automatic test_zero_reg;
    we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    step();
    we = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
    checks++;
    if (wr_drop !== 1'b0 || z_wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL zero_reg_drop: drop=%b nz_drop=%b, need 0", wr_drop, z_wr_drop);
    end
    step();
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg_read: rd1=%h rd2=%h, need 0", rdata1, rdata2);
    end
    checks++;
    if (z_rdata1 !== 32'h12345678) begin
      errors++;
      $display("FAIL nonzero_reg_read: rd1=%h, need 12345678", z_rdata1);
    end
  endtask

  task automatic test_bypass;
    logic [31:0] exp_new, exp_z;
`ifdef REGFILE_BYPASS_EN
    exp_new = 32'h2222;
    exp_z   = 32'h00000ABC;
`else
    exp_new = 32'h1111;
    exp_z   = 32'h12345678;
`endif
    we = 1'b1; waddr = 5'd7; wdata = 32'h1111;
    step();
    wdata = 32'h2222; raddr1 = 5'd7; raddr2 = 5'd5;
    step();
    checks++;
    if (rdata1 !== exp_new || rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL same_cycle_read: rd1=%h rd2=%h, need %h/deadbeef", rdata1, rdata2, exp_new);
    end
    we = 1'b0;
    step();
    checks++;
    if (rdata1 !== 32'h2222) begin
      errors++;
      $display("FAIL next_read: rd1=%h, need 2222", rdata1);
    end
    we = 1'b1; waddr = 5'd0; wdata = 32'h00000ABC; raddr1 = 5'd0;
    step();
    we = 1'b0;
    checks++;
    if (rdata1 !== 32'h0 || z_rdata1 !== exp_z) begin
      errors++;
      $display("FAIL zero_bypass: rd1=%h nz_rd1=%h, need 0/%h", rdata1, z_rdata1, exp_z);
    end
  endtask

  task automatic test_clear;
    int n;
    we = 1'b1; waddr = 5'd3; wdata = 32'h55; raddr1 = 5'd3;
    step();
    we = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (busy !== 1'b1 || rdata1 !== 32'h55) begin
      errors++;
      $display("FAIL clr_start: busy=%b rd1=%h, need 1/00000055", busy, rdata1);
    end
    we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
    step();
    we = 1'b0;
    checks++;
    if (wr_drop !== 1'b1 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL drop_pulse: drop=%b rd1=%h, need 1/0", wr_drop, rdata1);
    end
    step();
    checks++;
    if (wr_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_one_cycle: drop=%b, need 0", wr_drop);
    end
    count_busy(n);
    checks++;
    if (busy !== 1'b0 || n !== 30) begin
      errors++;
      $display("FAIL clr_busy_len: busy=%b after %0d more cycles, need 0 after 30", busy, n);
    end
    step();
    checks++;
    if (rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL clr_r3: rd1=%h, need 0", rdata1);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    repeat (2) step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_busy: busy=%b, need 1", busy);
    end
    rst = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL mid_reset_len: busy fell after %0d cycles, need 32", n);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
